// File: rtl/machine_fifos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : machine_fifos_pkg
//  Description : Shared flag indices and capacity-select encoding for the
//                host/machine FIFO pair.
//  Revision    : 1.0
// ============================================================================
package machine_fifos_pkg;

    localparam int NUM_FLAGS     = 4;
    localparam int FLAG_TX_OVER  = 0;
    localparam int FLAG_RX_UNDER = 1;
    localparam int FLAG_TX_STALL = 2;
    localparam int FLAG_RX_STALL = 3;

    typedef enum logic [1:0] {
        CAP_ZERO   = 2'd0,
        CAP_BASE   = 2'd1,
        CAP_DOUBLE = 2'd2
    } cap_sel_t;

    // A ring gives its storage away when its own direction is absorbed by the
    // other; joining both ways at once cancels out to the plain split.
    function automatic cap_sel_t cap_select(input logic give, input logic take);
        if (give && !take) return CAP_ZERO;
        if (take && !give) return CAP_DOUBLE;
        return CAP_BASE;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(2 * depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/machine_fifos_if.sv
`default_nettype none
// ============================================================================
//  Module      : machine_fifos_if
//  Description : Host/machine data, control and status bundle for
//                machine_fifos.
//  Revision    : 1.0
// ============================================================================
interface machine_fifos_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) ();
    localparam int LEVEL_W = machine_fifos_pkg::level_width(DEPTH);

    logic               flush;
    logic               join_tx;
    logic               join_rx;
    logic               host_wen;
    logic [WIDTH-1:0]   host_wdata;
    logic               host_ren;
    logic [WIDTH-1:0]   host_rdata;
    logic               mach_pull;
    logic [WIDTH-1:0]   mach_din;
    logic               mach_push;
    logic [WIDTH-1:0]   mach_dout;
    logic               tx_empty;
    logic               tx_full;
    logic               rx_empty;
    logic               rx_full;
    logic [LEVEL_W-1:0] tx_level;
    logic [LEVEL_W-1:0] rx_level;
    logic [3:0]         flags;
    logic [3:0]         flag_clear;

    modport master (
        output flush, join_tx, join_rx,
        output host_wen, host_wdata, host_ren,
        output mach_pull, mach_push, mach_dout,
        output flag_clear,
        input  host_rdata, mach_din,
        input  tx_empty, tx_full, rx_empty, rx_full,
        input  tx_level, rx_level, flags
    );

    modport slave (
        input  flush, join_tx, join_rx,
        input  host_wen, host_wdata, host_ren,
        input  mach_pull, mach_push, mach_dout,
        input  flag_clear,
        output host_rdata, mach_din,
        output tx_empty, tx_full, rx_empty, rx_full,
        output tx_level, rx_level, flags
    );
endinterface
`default_nettype wire

// File: rtl/machine_fifos_fifo_ring.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ring
//  Description : Show-ahead circular FIFO whose usable capacity is chosen at
//                run time, up to MAXDEPTH entries.
//  Revision    : 1.0
// ============================================================================
module fifo_ring #(
    parameter  int WIDTH    = 32,
    parameter  int MAXDEPTH = 8,
    localparam int PTR_W    = $clog2(MAXDEPTH),
    localparam int LEVEL_W  = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [LEVEL_W-1:0] capacity,
    input  logic               wen,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               ren,
    output logic [WIDTH-1:0]   rdata,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0]   r_mem [MAXDEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [LEVEL_W-1:0] w_wr_inc;
    logic [LEVEL_W-1:0] w_rd_inc;
    logic [PTR_W-1:0]   w_wr_next;
    logic [PTR_W-1:0]   w_rd_next;

    // A zero capacity makes the ring permanently full and empty, so every
    // write and pop is refused without a special case.
    assign w_full  = (r_level >= capacity);
    assign w_empty = (r_level == '0);
    assign w_wr_ok = wen & ~w_full;
    assign w_rd_ok = ren & ~w_empty;

    assign w_wr_inc  = {1'b0, r_wr_ptr} + LEVEL_W'(1);
    assign w_rd_inc  = {1'b0, r_rd_ptr} + LEVEL_W'(1);
    assign w_wr_next = (w_wr_inc >= capacity) ? '0 : w_wr_inc[PTR_W-1:0];
    assign w_rd_next = (w_rd_inc >= capacity) ? '0 : w_rd_inc[PTR_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= w_wr_next;
            if (w_rd_ok) r_rd_ptr <= w_rd_next;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !clear) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty = w_empty;
    assign full  = w_full;
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/machine_fifos.sv
`default_nettype none
// ============================================================================
//  Module      : machine_fifos
//  Description : Host-to-machine TX FIFO and machine-to-host RX FIFO with
//                storage joining, sticky error flags and flush control.
//  Revision    : 1.0
// ============================================================================
module machine_fifos
    import machine_fifos_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    machine_fifos_if.slave bus
);

    localparam int MAXDEPTH = 2 * DEPTH;
    localparam int LEVEL_W  = level_width(DEPTH);

    function automatic logic [LEVEL_W-1:0] cap_value(input cap_sel_t sel);
        case (sel)
            CAP_ZERO:   return '0;
            CAP_DOUBLE: return LEVEL_W'(MAXDEPTH);
            default:    return LEVEL_W'(DEPTH);
        endcase
    endfunction

    logic [1:0]           w_join;
    logic [1:0]           r_join;
    logic                 w_cfg_change;
    logic                 w_clear;
    logic                 w_tx_only;
    logic                 w_rx_only;
    logic                 w_swap;

    logic                 w_a_wen,   w_b_wen;
    logic [WIDTH-1:0]     w_a_wdata, w_b_wdata;
    logic                 w_a_ren,   w_b_ren;
    logic [WIDTH-1:0]     w_a_rdata, w_b_rdata;
    logic                 w_a_empty, w_b_empty;
    logic                 w_a_full,  w_b_full;
    logic [LEVEL_W-1:0]   w_a_level, w_b_level;
    logic [LEVEL_W-1:0]   w_a_cap,   w_b_cap;

    logic                 w_tx_empty, w_tx_full;
    logic                 w_rx_empty, w_rx_full;
    logic [NUM_FLAGS-1:0] w_flag_set;
    logic [NUM_FLAGS-1:0] r_flags;

    assign w_join       = {bus.join_tx, bus.join_rx};
    assign w_cfg_change = (w_join != r_join);
    assign w_clear      = bus.flush | w_cfg_change;

    assign w_tx_only = bus.join_tx & ~bus.join_rx;
    assign w_rx_only = bus.join_rx & ~bus.join_tx;
    assign w_swap    = w_tx_only | w_rx_only;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_join <= 2'b00;
        end else begin
            r_join <= w_join;
        end
    end

    // Ring A is the TX storage and ring B the RX storage. A join routes the
    // absorbed direction's traffic into the other ring and sets its own
    // ring to zero capacity, which then stands in as the disabled view.
    assign w_a_cap   = cap_value(cap_select(bus.join_tx, bus.join_rx));
    assign w_b_cap   = cap_value(cap_select(bus.join_rx, bus.join_tx));

    assign w_a_wen   = w_rx_only ? bus.mach_push : bus.host_wen;
    assign w_a_wdata = w_rx_only ? bus.mach_dout : bus.host_wdata;
    assign w_a_ren   = w_rx_only ? bus.host_ren  : bus.mach_pull;

    assign w_b_wen   = w_tx_only ? bus.host_wen   : bus.mach_push;
    assign w_b_wdata = w_tx_only ? bus.host_wdata : bus.mach_dout;
    assign w_b_ren   = w_tx_only ? bus.mach_pull  : bus.host_ren;

    fifo_ring #(
        .WIDTH    (WIDTH),
        .MAXDEPTH (MAXDEPTH)
    ) u_ring_tx (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .capacity (w_a_cap),
        .wen      (w_a_wen),
        .wdata    (w_a_wdata),
        .ren      (w_a_ren),
        .rdata    (w_a_rdata),
        .empty    (w_a_empty),
        .full     (w_a_full),
        .level    (w_a_level)
    );

    fifo_ring #(
        .WIDTH    (WIDTH),
        .MAXDEPTH (MAXDEPTH)
    ) u_ring_rx (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .capacity (w_b_cap),
        .wen      (w_b_wen),
        .wdata    (w_b_wdata),
        .ren      (w_b_ren),
        .rdata    (w_b_rdata),
        .empty    (w_b_empty),
        .full     (w_b_full),
        .level    (w_b_level)
    );

    assign w_tx_empty   = w_swap ? w_b_empty : w_a_empty;
    assign w_tx_full    = w_swap ? w_b_full  : w_a_full;
    assign w_rx_empty   = w_swap ? w_a_empty : w_b_empty;
    assign w_rx_full    = w_swap ? w_a_full  : w_b_full;

    assign bus.tx_empty   = w_tx_empty;
    assign bus.tx_full    = w_tx_full;
    assign bus.rx_empty   = w_rx_empty;
    assign bus.rx_full    = w_rx_full;
    assign bus.tx_level   = w_swap ? w_b_level : w_a_level;
    assign bus.rx_level   = w_swap ? w_a_level : w_b_level;
    assign bus.mach_din   = w_swap ? w_b_rdata : w_a_rdata;
    assign bus.host_rdata = w_swap ? w_a_rdata : w_b_rdata;

    always_comb begin
        w_flag_set                = '0;
        w_flag_set[FLAG_TX_OVER]  = bus.host_wen  & w_tx_full;
        w_flag_set[FLAG_RX_UNDER] = bus.host_ren  & w_rx_empty;
        w_flag_set[FLAG_TX_STALL] = bus.mach_pull & w_tx_empty;
        w_flag_set[FLAG_RX_STALL] = bus.mach_push & w_rx_full;
    end

    // A same-cycle set wins over write-1-to-clear so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else if (bus.flush) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~bus.flag_clear) | w_flag_set;
        end
    end

    assign bus.flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_machine_fifos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_machine_fifos
//  Description : Directed self-checking bench for machine_fifos.
//  Revision    : 1.0
// ============================================================================
module tb_machine_fifos;
    import machine_fifos_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    machine_fifos_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    machine_fifos #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.join_tx    = 1'b0;
        bus.join_rx    = 1'b0;
        bus.host_wen   = 1'b0;
        bus.host_wdata = '0;
        bus.host_ren   = 1'b0;
        bus.mach_pull  = 1'b0;
        bus.mach_push  = 1'b0;
        bus.mach_dout  = '0;
        bus.flag_clear = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        #3;
        checks++;
        if ({bus.tx_empty, bus.tx_full, bus.rx_empty, bus.rx_full} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_status got %b exp 1010",
                     {bus.tx_empty, bus.tx_full, bus.rx_empty, bus.rx_full});
        end
        checks++;
        if ({bus.tx_level, bus.rx_level, bus.flags} !== 12'h000) begin
            errors++;
            $display("FAIL reset_levels_flags got %h exp 000", {bus.tx_level, bus.rx_level, bus.flags});
        end
        checks++;
        if ({bus.host_rdata, bus.mach_din} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {bus.host_rdata, bus.mach_din});
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_tx_fill();
        for (int i = 1; i <= 4; i++) begin
            bus.host_wen = 1'b1; bus.host_wdata = 32'(i);
            tick();
        end
        checks++;
        if ({bus.tx_full, bus.tx_level} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL tx_fill_full got full=%b level=%0d exp full=1 level=4", bus.tx_full, bus.tx_level);
        end
        bus.host_wdata = 32'd5;
        tick();
        bus.host_wen = 1'b0;
        checks++;
        if ({bus.flags, bus.tx_level} !== {4'b0001, 4'd4}) begin
            errors++;
            $display("FAIL tx_over got flags=%b level=%0d exp flags=0001 level=4", bus.flags, bus.tx_level);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.mach_din !== 32'(i)) begin
                errors++;
                $display("FAIL tx_pull_order got %0d exp %0d", bus.mach_din, i);
            end
            bus.mach_pull = 1'b1;
            tick();
        end
        bus.mach_pull = 1'b0;
        checks++;
        if ({bus.tx_empty, bus.mach_din} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL tx_drained got empty=%b din=%0d exp empty=1 din=0", bus.tx_empty, bus.mach_din);
        end
        bus.flag_clear = 4'b0001;
        tick();
        bus.flag_clear = 4'b0000;
        checks++;
        if (bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL tx_over_clear got %b exp 0000", bus.flags);
        end
    endtask

    task automatic test_rx_stall();
        for (int i = 0; i < 4; i++) begin
            bus.mach_push = 1'b1; bus.mach_dout = 32'(10 + i);
            tick();
        end
        bus.mach_dout = 32'd99;
        bus.host_ren  = 1'b1;
        tick();
        bus.mach_push = 1'b0;
        bus.host_ren  = 1'b0;
        checks++;
        if ({bus.rx_level, bus.flags, bus.host_rdata} !== {4'd3, 4'b1000, 32'd11}) begin
            errors++;
            $display("FAIL rx_stall got level=%0d flags=%b head=%0d exp level=3 flags=1000 head=11",
                     bus.rx_level, bus.flags, bus.host_rdata);
        end
        for (int i = 11; i <= 13; i++) begin
            checks++;
            if (bus.host_rdata !== 32'(i)) begin
                errors++;
                $display("FAIL rx_drain_order got %0d exp %0d", bus.host_rdata, i);
            end
            bus.host_ren = 1'b1;
            tick();
        end
        tick();
        bus.host_ren = 1'b0;
        checks++;
        if ({bus.rx_empty, bus.flags} !== {1'b1, 4'b1010}) begin
            errors++;
            $display("FAIL rx_under got empty=%b flags=%b exp empty=1 flags=1010", bus.rx_empty, bus.flags);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL flush_flags got %b exp 0000", bus.flags);
        end
    endtask

    task automatic test_join_tx();
        bus.join_tx = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.host_wen = 1'b1; bus.host_wdata = 32'(20 + i);
            bus.mach_push = 1'b1; bus.mach_dout = 32'd77;
            tick();
        end
        bus.host_wen = 1'b0; bus.mach_push = 1'b0;
        checks++;
        if ({bus.tx_level, bus.tx_full, bus.mach_din} !== {4'd8, 1'b1, 32'd20}) begin
            errors++;
            $display("FAIL join_tx_fill got level=%0d full=%b head=%0d exp level=8 full=1 head=20",
                     bus.tx_level, bus.tx_full, bus.mach_din);
        end
        checks++;
        if ({bus.rx_full, bus.rx_empty, bus.rx_level, bus.flags} !== {1'b1, 1'b1, 4'd0, 4'b1000}) begin
            errors++;
            $display("FAIL join_tx_rx_off got full=%b empty=%b level=%0d flags=%b exp 1 1 0 1000",
                     bus.rx_full, bus.rx_empty, bus.rx_level, bus.flags);
        end
        bus.join_tx = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if ({bus.tx_level, bus.tx_empty, bus.flags} !== {4'd0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL unjoin_flush got level=%0d empty=%b flags=%b exp 0 1 0000",
                     bus.tx_level, bus.tx_empty, bus.flags);
        end
    endtask

    task automatic test_both_join();
        bus.join_tx = 1'b1; bus.join_rx = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.host_wen = 1'b1; bus.host_wdata = 32'(30 + i);
            tick();
        end
        bus.host_wen = 1'b0;
        checks++;
        if ({bus.tx_level, bus.tx_full, bus.flags, bus.rx_full} !== {4'd4, 1'b1, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL both_join got level=%0d full=%b flags=%b rx_full=%b exp 4 1 0001 0",
                     bus.tx_level, bus.tx_full, bus.flags, bus.rx_full);
        end
        bus.join_tx = 1'b0; bus.join_rx = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_wrap();
        bus.host_wen = 1'b1; bus.host_wdata = 32'd100;
        tick();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if ({bus.mach_din, bus.tx_level} !== {32'(100 + k), 4'd1}) begin
                errors++;
                $display("FAIL wrap_order got din=%0d level=%0d exp din=%0d level=1",
                         bus.mach_din, bus.tx_level, 100 + k);
            end
            bus.host_wen = 1'b1; bus.host_wdata = 32'(101 + k);
            bus.mach_pull = 1'b1;
            tick();
        end
        bus.host_wen = 1'b0;
        checks++;
        if (bus.mach_din !== 32'd109) begin
            errors++;
            $display("FAIL wrap_last got %0d exp 109", bus.mach_din);
        end
        tick();
        bus.mach_pull = 1'b0;
        checks++;
        if (bus.tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_empty got %b exp 1", bus.tx_empty);
        end
    endtask

    task automatic test_join_change_reset();
        for (int i = 1; i <= 3; i++) begin
            bus.host_wen = 1'b1; bus.host_wdata = 32'(i);
            tick();
        end
        bus.host_wen = 1'b0;
        bus.join_rx  = 1'b1;
        tick();
        checks++;
        if ({bus.tx_level, bus.rx_level, bus.tx_full, bus.tx_empty, bus.rx_full} !==
            {4'd0, 4'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL join_rx_flush got tx=%0d rx=%0d tfull=%b tempty=%b rfull=%b exp 0 0 1 1 0",
                     bus.tx_level, bus.rx_level, bus.tx_full, bus.tx_empty, bus.rx_full);
        end
        for (int i = 0; i < 2; i++) begin
            bus.mach_push = 1'b1; bus.mach_dout = 32'(40 + i);
            bus.host_wen  = 1'b1;
            tick();
        end
        checks++;
        if ({bus.rx_level, bus.host_rdata, bus.flags} !== {4'd2, 32'd40, 4'b0001}) begin
            errors++;
            $display("FAIL join_rx_burst got level=%0d head=%0d flags=%b exp 2 40 0001",
                     bus.rx_level, bus.host_rdata, bus.flags);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.rx_level, bus.rx_empty, bus.host_rdata, bus.flags} !== {4'd0, 1'b1, 32'd0, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset got level=%0d empty=%b head=%0d flags=%b exp 0 1 0 0000",
                     bus.rx_level, bus.rx_empty, bus.host_rdata, bus.flags);
        end
        idle();
        #1;
        checks++;
        if ({bus.tx_empty, bus.tx_full, bus.rx_empty, bus.rx_full, bus.mach_din} !== {4'b1010, 32'd0}) begin
            errors++;
            $display("FAIL reset_unjoined got %b din=%0d exp 1010 din=0",
                     {bus.tx_empty, bus.tx_full, bus.rx_empty, bus.rx_full}, bus.mach_din);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stall_clear();
        bus.mach_pull  = 1'b1;
        bus.host_wen   = 1'b1; bus.host_wdata = 32'd55;
        bus.flag_clear = 4'b0100;
        tick();
        bus.host_wen = 1'b0;
        checks++;
        if ({bus.flags, bus.tx_level, bus.mach_din} !== {4'b0100, 4'd1, 32'd55}) begin
            errors++;
            $display("FAIL stall_vs_clear got flags=%b level=%0d din=%0d exp 0100 1 55",
                     bus.flags, bus.tx_level, bus.mach_din);
        end
        tick();
        bus.mach_pull  = 1'b0;
        bus.flag_clear = 4'b0000;
        checks++;
        if ({bus.flags, bus.tx_empty} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL stall_cleared got flags=%b empty=%b exp 0000 1", bus.flags, bus.tx_empty);
        end
    endtask

    initial begin
        test_reset();
        test_tx_fill();
        test_rx_stall();
        test_join_tx();
        test_both_join();
        test_wrap();
        test_join_change_reset();
        test_stall_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/machine_fifos.md
MACHINE_FIFOS -- requirements
Module: machine_fifos

Interface
REQ-001 Parameter WIDTH, default 32, sets the FIFO word width.
REQ-002 Parameter DEPTH, default 4, sets the per-direction depth when unjoined; the joined depth is 2*DEPTH.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-005 flush  in  1  synchronous clear of both FIFOs and all flags; pairs with machine restart.
REQ-006 join_tx  in  1  TX takes the RX storage (depth 2*DEPTH); RX disabled.
REQ-007 join_rx  in  1  RX takes the TX storage (depth 2*DEPTH); TX disabled.
REQ-008 host_wen / host_wdata  in  1 / WIDTH  host write into TX.
REQ-009 host_ren  in  1  host pop from RX; host_rdata  out  WIDTH  RX head (show-ahead).
REQ-010 mach_pull  in  1  machine pop from TX; mach_din  out  WIDTH  TX head (show-ahead).
REQ-011 mach_push / mach_dout  in  1 / WIDTH  machine write into RX.
REQ-012 tx_empty, tx_full, rx_empty, rx_full  out  1 each  registered-state status.
REQ-013 tx_level, rx_level  out  clog2(2*DEPTH)+1  current occupancy.
REQ-014 flags  out  4  sticky {rx_stall, tx_stall, rx_under, tx_over}; flag_clear  in  4  write-1-to-clear.

Function
REQ-015 Each FIFO SHALL be a circular buffer with read/write pointers and an occupancy count; head data SHALL be visible combinationally (no read latency).
REQ-016 A write SHALL be accepted only when the registered level is below capacity. A pop SHALL be accepted only when the registered level is nonzero. Accepted operations take effect at the next edge.
REQ-017 Simultaneous accepted write and pop on one FIFO SHALL leave the level unchanged and advance both pointers.
REQ-018 A write when full SHALL be rejected, even with a same-cycle pop. A pop when empty SHALL be rejected, even with a same-cycle write (no fall-through).
REQ-019 Pointers SHALL wrap modulo the current capacity.
REQ-020 Capacity: neither join -> DEPTH/DEPTH. join_tx only -> TX 2*DEPTH, RX 0. join_rx only -> RX 2*DEPTH, TX 0. Both set -> DEPTH/DEPTH.
REQ-021 A capacity-0 FIFO SHALL report full=1, empty=1, level=0, and SHALL ignore writes and pops.
REQ-022 Any change of join_tx or join_rx SHALL flush both FIFOs on the following edge.
REQ-023 Sticky flags:
- tx_over: host_wen while tx_full.
- rx_under: host_ren while rx_empty.
- tx_stall: mach_pull while tx_empty.
- rx_stall: mach_push while rx_full.
REQ-024 A flag set event and a flag_clear on the same bit in the same cycle SHALL leave the bit set.
REQ-025 Rejected writes SHALL not alter storage. host_rdata and mach_din SHALL read 0 when their FIFO is empty.
REQ-026 mach_push and mach_pull MAY be held high for multiple cycles while the machine stalls; each cycle SHALL be evaluated independently.
REQ-027 flush SHALL take priority over all same-cycle writes and pops.

Reset
REQ-028 While reset=0: all pointers, levels and flags SHALL be 0; tx_empty=rx_empty=1; tx_full=rx_full=0 (unjoined); host_rdata=mach_din=0.
REQ-029 Reset asserted mid-operation SHALL discard all contents immediately. Storage contents need not be reset.

Structure
REQ-030 A shared package SHALL hold the flag bit-index constants and the capacity-select encoding.
REQ-031 Sub-module fifo_ring (WIDTH, MAXDEPTH=2*DEPTH, runtime capacity input) SHALL be instantiated twice, once for TX and once for RX.
REQ-032 Join muxing, flag logic and configuration-change detection SHALL reside in machine_fifos.

Verification
REQ-033 Unjoined TX: write 1,2,3,4 -> tx_full=1 and tx_level=4. A 5th write -> tx_over=1, data dropped. Four pulls -> mach_din sequence 1,2,3,4, then tx_empty=1.
REQ-034 RX push with RX full and a same-cycle host_ren -> pop accepted, push rejected, rx_stall=1, rx_level=3.
REQ-035 join_tx=1: eight writes accepted, tx_level=8; rx_full=rx_empty=1; mach_push ignored.
REQ-036 Wrap: write/pull 10 words through TX at level 1-2 -> data order preserved across pointer wrap.
REQ-037 Toggle join_rx with 3 words in TX -> both levels become 0 next cycle. Then assert reset low mid-burst -> all status outputs return to reset values asynchronously.
REQ-038 Pull while empty with flag_clear[tx_stall]=1 in the same cycle -> tx_stall remains 1. Clear it the next cycle -> 0.
